// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - sync/payload/checksum frame decoder behind the UART receiver
// Optional inter-byte timeout: define UART_RX_FRAME_TIMEOUT_EN to build it.
module uart_rx_frame #(
  parameter int         PAYLOAD_BYTES  = 4,
  parameter logic [7:0] SYNC           = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 2000000,
  parameter int         TO_BIT         = 21
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_done_tick,
  input  logic [7:0]                 rx_data,
  output logic                       frame_valid,
  output logic [8*PAYLOAD_BYTES-1:0] frame_data,
  output logic                       err_checksum,
  output logic                       err_timeout,
  output logic [7:0]                 err_count,
  output logic                       busy
);

  localparam int IDX_W = $clog2(PAYLOAD_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } state_t;

  state_t                     state;
  state_t                     state_next;
  logic [IDX_W-1:0]           idx;
  logic [7:0]                 sum;
  logic [8*PAYLOAD_BYTES-1:0] staging;
  logic                       expired;
  logic                       do_accept;
  logic                       do_reject;
  logic                       do_timeout;

`ifdef UART_RX_FRAME_TIMEOUT_EN
  localparam logic [TO_BIT-1:0] TO_LAST = TO_BIT'(TIMEOUT_CYCLES - 1);

  logic [TO_BIT-1:0] to_cnt;

  // A byte arriving in the expiry cycle wins, so expiry requires no tick.
  assign expired = (state != ST_IDLE) && !rx_done_tick && (to_cnt == TO_LAST);

  // Inter-byte idle counter: counts only while a frame is open, cleared by every byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (rx_done_tick || state_next == ST_IDLE) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  // Without the timeout a stalled frame simply waits for its remaining bytes.
  assign expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; SYNC is only special in IDLE, inside a frame it is plain data.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (rx_done_tick && rx_data == SYNC) state_next = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (expired)                              state_next = ST_IDLE;
        else if (rx_done_tick && idx == LAST_IDX) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (expired || rx_done_tick) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Frame outcome decode, registered into the pulse outputs below.
  always_comb begin
    do_accept  = 1'b0;
    do_reject  = 1'b0;
    do_timeout = expired;
    if (state == ST_CHECK && rx_done_tick) begin
      do_accept = (rx_data == sum);
      do_reject = (rx_data != sum);
    end
  end

  // Staging datapath: payload bytes land by slot and the running sum wraps at 8 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx     <= '0;
      sum     <= '0;
      staging <= '0;
    end else if (rx_done_tick) begin
      if (state == ST_IDLE && rx_data == SYNC) begin
        idx <= '0;
        sum <= '0;
      end else if (state == ST_PAYLOAD) begin
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
          if (idx == IDX_W'(i)) staging[i*8 +: 8] <= rx_data;
        end
        sum <= sum + rx_data;
        idx <= idx + 1'b1;
      end
    end
  end

  // Registered outputs; frame_data is only touched by an accepted frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_valid  <= 1'b0;
      frame_data   <= '0;
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
      err_count    <= '0;
      busy         <= 1'b0;
    end else begin
      frame_valid  <= do_accept;
      err_checksum <= do_reject;
      err_timeout  <= do_timeout;
      busy         <= (state_next != ST_IDLE);
      if (do_accept) frame_data <= staging;
      if ((do_reject || do_timeout) && err_count != 8'hFF) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - directed and random frame bench for uart_rx_frame
module tb_uart_rx_frame;

  localparam int PB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_done_tick;
  logic [7:0]    rx_data;
  logic          frame_valid;
  logic [8*PB-1:0] frame_data;
  logic          err_checksum;
  logic          err_timeout;
  logic [7:0]    err_count;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Reference model state: last accepted payload and saturating error count.
  logic [31:0] m_data = '0;
  int          m_errs = 0;

  always #5 clk = ~clk;

  uart_rx_frame #(
    .PAYLOAD_BYTES  (PB),
    .SYNC           (8'hA5),
    .TIMEOUT_CYCLES (100),
    .TO_BIT         (7)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .frame_valid  (frame_valid),
    .frame_data   (frame_data),
    .err_checksum (err_checksum),
    .err_timeout  (err_timeout),
    .err_count    (err_count),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; presents one byte for exactly one rising edge.
  task automatic send_byte(input logic [7:0] b);
    rx_done_tick = 1'b1;
    rx_data      = b;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_error();
    if (m_errs < 255) m_errs++;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(frame_valid), 64'd0);
    chk({tag, "_data"}, 64'(frame_data), 64'd0);
    chk({tag, "_cksum"}, 64'(err_checksum), 64'd0);
    chk({tag, "_tmo"}, 64'(err_timeout), 64'd0);
    chk({tag, "_cnt"}, 64'(err_count), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Sends SYNC, payload (byte 0 first) and checksum; the model decides the outcome.
  task automatic run_frame(input string tag, input logic [31:0] pl, input logic [7:0] ck,
                           input int gap, input bit tail);
    int  total;
    bit  ok;
    total = 0;
    for (int i = 0; i < PB; i++) total += int'(pl[i*8 +: 8]);
    ok = ((total % 256) == int'(ck));
    send_byte(8'hA5);
    chk({tag, "_busy_sync"}, 64'(busy), 64'd1);
    idle(gap);
    for (int i = 0; i < PB; i++) begin
      send_byte(pl[i*8 +: 8]);
      idle(gap);
    end
    chk({tag, "_busy_pre"}, 64'(busy), 64'd1);
    chk({tag, "_valid_pre"}, 64'(frame_valid), 64'd0);
    send_byte(ck);
    if (ok) m_data = pl;
    else    model_error();
    chk({tag, "_valid"}, 64'(frame_valid), 64'(ok));
    chk({tag, "_cksum"}, 64'(err_checksum), 64'(!ok));
    chk({tag, "_data"}, 64'(frame_data), 64'(m_data));
    chk({tag, "_cnt"}, 64'(err_count), 64'(m_errs));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    if (tail) begin
      idle(1);
      chk({tag, "_valid_fall"}, 64'(frame_valid), 64'd0);
      chk({tag, "_cksum_fall"}, 64'(err_checksum), 64'd0);
    end
  endtask

  initial begin
    int         n;
    bit         seen;
    logic [31:0] pl;
    logic [7:0]  ck;
    logic [7:0]  g;
    int          total;

    reset        = 1'b0;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
    idle(3);
    check_all_zero("reset");
    reset = 1'b1;
    idle(2);

    run_frame("good", 32'h04030201, 8'h0A, 16, 1'b1);
    run_frame("wrap", 32'h0201FFFF, 8'h01, 2, 1'b1);
    run_frame("bad", 32'h04030201, 8'h0B, 1, 1'b1);

    send_byte(8'h00);
    send_byte(8'h3C);
    chk("garbage_busy", 64'(busy), 64'd0);
    run_frame("embed", 32'h3322A511, 8'h0B, 0, 1'b1);

    // Back-to-back: the next SYNC arrives in the cycle right after a checksum.
    run_frame("b2b_a", 32'h44332211, 8'hAA, 0, 1'b0);
    run_frame("b2b_b", 32'h01020304, 8'h0A, 0, 1'b1);

    send_byte(8'hA5);
    send_byte(8'h01);
`ifdef UART_RX_FRAME_TIMEOUT_EN
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      seen = err_timeout;
    end
    model_error();
    chk("tmo_seen", 64'(seen), 64'd1);
    chk("tmo_latency", 64'(n), 64'd100);
    chk("tmo_busy", 64'(busy), 64'd0);
    chk("tmo_cnt", 64'(err_count), 64'(m_errs));
    idle(1);
    chk("tmo_fall", 64'(err_timeout), 64'd0);
    run_frame("after_tmo", 32'h0D0C0B0A, 8'h2E, 3, 1'b1);
`else
    seen = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      seen |= err_timeout;
    end
    chk("stall_no_tmo", 64'(seen), 64'd0);
    chk("stall_busy", 64'(busy), 64'd1);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h0A);
    m_data = 32'h04030201;
    chk("stall_valid", 64'(frame_valid), 64'd1);
    chk("stall_data", 64'(frame_data), 64'(m_data));
    idle(1);
`endif

    send_byte(8'hA5);
    send_byte(8'h01);
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    idle(2);
    reset  = 1'b1;
    m_data = '0;
    m_errs = 0;
    idle(1);
    run_frame("post_reset", 32'h78563412, 8'h14, 1, 1'b1);

    for (int k = 0; k < 24; k++) begin
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g);
      end
      pl    = $urandom;
      total = 0;
      for (int i = 0; i < PB; i++) total += int'(pl[i*8 +: 8]);
      ck = 8'(total);
      if ($urandom_range(0, 1) == 1) ck = ck ^ 8'($urandom_range(1, 255));
      run_frame("rand", pl, ck, int'($urandom_range(0, 3)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Receive-side frame decoder that sits behind the UART receiver and consumes its byte stream (`rx_done_tick` plus `dout`). It recovers fixed-length frames from that stream and publishes each validated payload as one wide register with a single-cycle valid strobe. Each frame is a sync byte, `PAYLOAD_BYTES` payload bytes, then an 8-bit checksum byte. It is the receiving end of the framed link that carries game state between boards.

## Interface
- `PAYLOAD_BYTES`, 4: payload bytes per frame; legal range 1..16.
- `SYNC`, 8'hA5: frame start byte.
- `TIMEOUT_CYCLES`, 2000000: maximum clk cycles allowed between bytes inside a frame.
- `TO_BIT`, 21: width of the timeout counter; must satisfy 2^TO_BIT > TIMEOUT_CYCLES.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rx_done_tick` in 1: one-cycle strobe meaning a new byte is present on `rx_data`.
- `rx_data` in 8: received byte; sampled only when `rx_done_tick` = 1.
- `frame_valid` out 1: one-cycle pulse when a good frame is accepted.
- `frame_data` out 8*PAYLOAD_BYTES: payload of the last good frame.
- `err_checksum` out 1: one-cycle pulse when a frame fails its checksum.
- `err_timeout` out 1: one-cycle pulse when a frame is abandoned on timeout.
- `err_count` out 8: saturating count of checksum and timeout errors.
- `busy` out 1: high while a frame is in progress, i.e. state is not IDLE.

## Operation
- States:
  - IDLE: discard every byte except `SYNC`; on `SYNC`, clear the byte index and the running sum, then go to PAYLOAD.
  - PAYLOAD: each tick writes `rx_data` into the staging register at slot `idx` (byte 0 occupies bits [7:0]), adds it to `sum` modulo 256 and increments `idx`. The tick carrying byte `PAYLOAD_BYTES-1` moves to CHECK.
  - CHECK: the next tick carries the checksum byte.
    - If it equals `sum`: copy staging into `frame_data`, pulse `frame_valid`, go to IDLE.
    - Otherwise: pulse `err_checksum`, leave `frame_data` unchanged, go to IDLE.
- A `SYNC` value arriving inside PAYLOAD or CHECK is ordinary data; it does not restart the frame.
- `frame_data` changes only on an accepted frame and holds its value between frames.
- `err_count` increments on every `err_checksum` or `err_timeout` pulse and saturates at 8'hFF.
- Checksum is the 8-bit sum of the payload bytes only; the sync byte is excluded and carries wrap.
- The staging register is separate from `frame_data`, so a partial or bad frame never corrupts the published payload.

## Timing
- Reset values: state IDLE, `frame_valid` 0, `frame_data` 0, `err_checksum` 0, `err_timeout` 0, `err_count` 0, `busy` 0, `idx` 0, `sum` 0, timeout counter 0.
- All outputs are registered.
- `frame_valid` or `err_checksum` is high in the cycle after the checksum byte's `rx_done_tick`.
- `frame_data` is updated on the same edge that raises `frame_valid`.
- `busy` rises the cycle after the sync tick and falls in the same cycle as the frame's `frame_valid` / `err_checksum` / `err_timeout` pulse.
- Back-to-back frames are supported: a `SYNC` tick in the cycle right after the CHECK byte is accepted, because state is already IDLE.
- Reset asserted mid-frame: everything returns to reset values immediately; no pulse is emitted.
- `rx_done_tick` held high for several cycles is treated as one byte per cycle. The upstream receiver guarantees single-cycle strobes.

## Configuration
- `UART_RX_FRAME_TIMEOUT_EN` defined:
  - The timeout counter runs in PAYLOAD and CHECK and clears on every `rx_done_tick`.
  - When the counter reaches `TIMEOUT_CYCLES-1` with no tick, the block pulses `err_timeout` on the next cycle and goes to IDLE.
  - If a tick and expiry coincide, the byte wins and no timeout is raised.
- `UART_RX_FRAME_TIMEOUT_EN` undefined:
  - No counter is built; `err_timeout` is tied to 0.
  - A stalled frame waits indefinitely for its remaining bytes.

## Test plan
- Good frame (A5, 01, 02, 03, 04, 0A), ticks 16 cycles apart -> one `frame_valid` pulse the cycle after the 0A tick; `frame_data` = 32'h04030201; `err_count` = 0.
- Checksum wrap (A5, FF, FF, 01, 02, checksum 01) -> `frame_valid` pulses; `frame_data` = 32'h0201FFFF.
- Bad checksum (A5, 01, 02, 03, 04, 0B) -> `err_checksum` pulses once; `frame_data` keeps its previous value; `err_count` = 1.
- Leading garbage 00, 3C, then a good frame containing A5 as payload byte 1 -> garbage ignored; embedded A5 stored as data; `frame_valid` pulses once.
- With the macro and `TIMEOUT_CYCLES` = 100: send A5, 01, then stall 100 cycles -> `err_timeout` pulses; `busy` = 0. A following good frame is then accepted.
- Reset pulsed low after A5, 01 -> all outputs read zero. A complete frame sent afterwards is accepted normally.
